dmem_access_unit: RTL and testbench

- Initiator that drives the data memory port (mem_we / mem_a / mem_d, combinational read data mem_spo) on behalf of the core.
- Accepts single-beat or burst requests over a valid/ready handshake.
  - Stores are fills: one value written to N consecutive addresses.
  - Loads stream N words back over a response channel with backpressure.
- Sits between the processor datapath and the 256x9 data memory.

---
 rtl/dmem_access_unit.sv | 136 +++++++++++++
 tb/tb_dmem_access_unit.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data memory initiator with fill-store and streaming-load bursts
//
// Purpose: accepts single-beat or burst requests from the core and drives the
// data memory port. Stores fill req_len+1 consecutive words with one value;
// loads stream req_len+1 words back over a backpressured response channel.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake
//   req_we/addr/wdata/len    request fields (len = beats minus one)
//   rsp_valid/rsp_ready      load response handshake
//   rsp_data/rsp_last        load word and final-beat flag
//   busy, done               activity flag, store-completion pulse
//   mem_we/mem_a/mem_d       memory write enable, address, write data
//   mem_spo                  memory read data (combinational from mem_a)

module dmem_access_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] r_hold_a;
  logic [LEN_W-1:0]  r_count;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hold_d;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic              r_done;

  logic              w_last_beat;
  logic              w_issue;

  assign w_last_beat = (r_count == '0);
  // A load beat may issue when the response register is empty or being drained.
  assign w_issue     = !r_rsp_valid || rsp_ready;

  // Derived from registered state only, so rsp_ready never reaches req_ready.
  assign req_ready = (r_state == S_IDLE) && !r_rsp_valid;
  assign busy      = (r_state != S_IDLE);
  // Write enable is a pure state decode: reset removes it in the same instant.
  assign mem_we    = (r_state == S_STORE);
  // While idle the memory port keeps the last address/data it actually used.
  assign mem_a     = (r_state == S_IDLE) ? r_hold_a : r_cur_addr;
  assign mem_d     = (r_state == S_IDLE) ? r_hold_d : r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign done      = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_hold_a    <= '0;
      r_count     <= '0;
      r_wdata     <= '0;
      r_hold_d    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_hold_a <= r_cur_addr;
        r_hold_d <= r_wdata;
      end
      case (r_state)
        S_IDLE: begin
          // Final load beat may still be waiting for the consumer.
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
          end
          if (req_valid && req_ready) begin
            r_cur_addr <= req_addr;
            r_count    <= req_len;
            r_wdata    <= req_wdata;
            r_state    <= req_we ? S_STORE : S_LOAD;
          end
        end
        S_STORE: begin
          r_cur_addr <= r_cur_addr + 1'b1;
          r_count    <= r_count - 1'b1;
          if (w_last_beat) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_issue) begin
            r_rsp_data  <= mem_spo;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= w_last_beat;
            r_cur_addr  <= r_cur_addr + 1'b1;
            r_count     <= r_count - 1'b1;
            if (w_last_beat) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit

module tb_dmem_access_unit;

  localparam int AW = 8;
  localparam int DW = 9;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_spo;

  always #5 clk = ~clk;

  dmem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_d     (mem_d),
    .mem_spo   (mem_spo)
  );

  // Physical memory attached to the port, and the bench's own reference image.
  logic [DW-1:0] tb_mem   [256];
  logic [DW-1:0] init_img [256];
  int            ref_mem  [256];
  logic          load_init = 1'b0;
  int            phys_writes = 0;

  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= init_img[i];
    end else if (mem_we) begin
      tb_mem[mem_a] <= mem_d;
      phys_writes++;
    end
  end

  assign mem_spo = tb_mem[mem_a];

  // Consumer readiness: fixed value or random per cycle.
  logic rdy_mode = 1'b0;
  logic rdy_val  = 1'b1;
  logic rdy_rand = 1'b1;
  always @(posedge clk) begin
    #1 rdy_rand = ($urandom_range(3) != 0);
  end
  assign rsp_ready = rdy_mode ? rdy_rand : rdy_val;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int a; int d; int c; } wrec_t;
  typedef struct { int d; int l; int c; } rrec_t;
  wrec_t wlog[$];
  rrec_t rlog[$];
  int    done_cnt = 0;
  int    busy_cnt = 0;
  int    inv_viol = 0;
  int    last_cons_cyc = -1;

  always @(negedge clk) begin
    if (mem_we) wlog.push_back('{a: int'(mem_a), d: int'(mem_d), c: cyc});
    if (rsp_valid && rsp_ready) begin
      rlog.push_back('{d: int'(rsp_data), l: int'(rsp_last), c: cyc});
      if (rsp_last) last_cons_cyc = cyc;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (req_ready && (busy || rsp_valid)) inv_viol++;
    if (rsp_valid && mem_we) inv_viol++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic start_req(input bit we, input int addr, input int wdata, input int len);
    req_we    = we;
    req_addr  = addr[AW-1:0];
    req_wdata = wdata[DW-1:0];
    req_len   = len[LW-1:0];
    req_valid = 1'b1;
  endtask

  task automatic wait_accept(output int acc);
    int n;
    n   = 0;
    acc = -1;
    while (n < 300) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        break;
      end
      n++;
    end
    if (acc < 0) begin
      req_valid = 1'b0;
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!busy && !rsp_valid) break;
      n++;
    end
    if (n >= 400) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Compare everything observed since the snapshots against the request's meaning.
  task automatic check_req(input bit we, input int addr, input int wdata, input int len,
                           input bit timed, input int acc,
                           input int wb, input int rb, input int db, input int bb);
    if (we) begin
      chk("store_nwrites", wlog.size() - wb, len + 1);
      for (int i = 0; i <= len; i++) begin
        if (wb + i < wlog.size()) begin
          chk("store_addr",  wlog[wb+i].a, (addr + i) % 256);
          chk("store_data",  wlog[wb+i].d, wdata);
          chk("store_cycle", wlog[wb+i].c, acc + i);
        end
        ref_mem[(addr + i) % 256] = wdata;
      end
      chk("store_done",   done_cnt - db, 1);
      chk("store_busy",   busy_cnt - bb, len + 1);
      chk("store_no_rsp", rlog.size() - rb, 0);
    end else begin
      chk("load_nbeats", rlog.size() - rb, len + 1);
      for (int i = 0; i <= len; i++) begin
        if (rb + i < rlog.size()) begin
          chk("load_data", rlog[rb+i].d, ref_mem[(addr + i) % 256]);
          chk("load_last", rlog[rb+i].l, (i == len) ? 1 : 0);
          if (timed) chk("load_cycle", rlog[rb+i].c, acc + 1 + i);
        end
      end
      chk("load_no_done",  done_cnt - db, 0);
      chk("load_no_write", wlog.size() - wb, 0);
    end
  endtask

  task automatic run_req(input bit we, input int addr, input int wdata, input int len,
                         input bit timed);
    int wb, rb, db, bb, acc;
    wb = wlog.size();
    rb = rlog.size();
    db = done_cnt;
    bb = busy_cnt;
    start_req(we, addr, wdata, len);
    wait_accept(acc);
    wait_idle();
    check_req(we, addr, wdata, len, timed, acc, wb, rb, db, bb);
  endtask

  typedef struct {
    bit we;
    int addr;
    int wdata;
    int len;
    int exp_n;      // writes for stores, beats for loads
    int exp_first;  // first write address / first load word
    int exp_last;   // last write address / last load word
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   wb, rb, db, bb, acc, acc2, p0;
    int   n_obs, first_obs, last_obs;

    vecs[0] = '{1'b1, 'h10, 'h1A5, 0,  1,  'h10,  'h10};
    vecs[1] = '{1'b1, 'hFE, 'h0FF, 3,  4,  'hFE,  'h01};
    vecs[2] = '{1'b0, 'h20, 0,     3,  4,  'h101, 'h104};
    vecs[3] = '{1'b0, 'hFE, 0,     3,  4,  'h0FF, 'h0FF};
    vecs[4] = '{1'b1, 'h80, 'h1F0, 15, 16, 'h80,  'h8F};
    vecs[5] = '{1'b0, 'h8F, 0,     0,  1,  'h1F0, 'h1F0};

    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    for (int i = 0; i < 256; i++) init_img[i] = DW'($urandom_range(511));
    for (int i = 0; i < 4; i++) init_img['h20 + i] = DW'('h101 + i);
    for (int i = 0; i < 256; i++) ref_mem[i] = int'(init_img[i]);
    load_init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_init = 1'b0;

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy",      busy, 0);
    chk("rst_done",      done, 0);
    chk("rst_mem_we",    mem_we, 0);
    chk("rst_mem_a",     mem_a, 0);
    chk("rst_mem_d",     mem_d, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last",  rsp_last, 0);
    chk("rst_rsp_data",  rsp_data, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table, consumer always ready
    rdy_mode = 1'b0;
    rdy_val  = 1'b1;
    foreach (vecs[k]) begin
      wb = wlog.size();
      rb = rlog.size();
      run_req(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].len, 1'b1);
      if (vecs[k].we) begin
        n_obs     = wlog.size() - wb;
        first_obs = (n_obs > 0) ? wlog[wb].a : -1;
        last_obs  = (n_obs > 0) ? wlog[wlog.size()-1].a : -1;
      end else begin
        n_obs     = rlog.size() - rb;
        first_obs = (n_obs > 0) ? rlog[rb].d : -1;
        last_obs  = (n_obs > 0) ? rlog[rlog.size()-1].d : -1;
      end
      chk("vec_count", n_obs, vecs[k].exp_n);
      chk("vec_first", first_obs, vecs[k].exp_first);
      chk("vec_last",  last_obs, vecs[k].exp_last);
    end

    // Backpressure on beat 2 of a load burst
    wb = wlog.size(); rb = rlog.size(); db = done_cnt; bb = busy_cnt;
    start_req(1'b0, 'h20, 0, 3);
    wait_accept(acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data",  rsp_data, 'h102);
      chk("bp_mem_a", mem_a, 'h22);
      @(posedge clk); #1;
    end
    rdy_val = 1'b1;
    wait_idle();
    check_req(1'b0, 'h20, 0, 3, 1'b0, acc, wb, rb, db, bb);

    // Reset in the middle of an 8-beat fill
    p0 = phys_writes;
    start_req(1'b1, 'h40, 'h123, 7);
    wait_accept(acc);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    chk("mrst_mem_we",    mem_we, 0);
    chk("mrst_busy",      busy, 0);
    chk("mrst_done",      done, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_mem_a",     mem_a, 0);
    chk("mrst_mem_d",     mem_d, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_writes",    phys_writes - p0, 3);
    for (int i = 0; i < 3; i++) ref_mem['h40 + i] = 'h123;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_no_more_writes", phys_writes - p0, 3);
    chk("mrst_mem_43", int'(tb_mem['h43]), ref_mem['h43]);
    rst = 1'b1;
    @(posedge clk); #1;
    run_req(1'b1, 'h43, 'h0AB, 1, 1'b1);
    run_req(1'b0, 'h3F, 0, 5, 1'b1);

    // Request held valid across a stalled load burst
    wb = wlog.size(); rb = rlog.size(); db = done_cnt; bb = busy_cnt;
    rdy_val = 1'b0;
    start_req(1'b0, 'h20, 0, 3);
    wait_accept(acc);
    start_req(1'b1, 'h90, 'h0AA, 0);
    repeat (5) begin @(posedge clk); #1; end
    rdy_val = 1'b1;
    wait_accept(acc2);
    chk("hs_accept_after_drain", acc2, last_cons_cyc + 2);
    check_req(1'b0, 'h20, 0, 3, 1'b0, acc, wb, rb, db, bb);
    wb = wlog.size(); rb = rlog.size(); db = done_cnt; bb = busy_cnt;
    wait_idle();
    check_req(1'b1, 'h90, 'h0AA, 0, 1'b1, acc2, wb, rb, db, bb);

    // Random traffic with random consumer readiness
    rdy_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bit we;
      we = bit'($urandom_range(1));
      run_req(we, int'($urandom_range(255)), int'($urandom_range(511)),
              int'($urandom_range(15)), 1'b0);
    end
    rdy_mode = 1'b0;

    chk("ready_and_rsp_invariants", inv_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
